// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RV32I sequencer: FSM states, opcodes
// and control-field values driven onto the datapath.
package multicycle_control_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK,
        S_TRAP
    } state_t;

    localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
    localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
    localparam logic [6:0] OPCODE_OP       = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
    localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL      = 7'b1101111;

    localparam logic       CTL_MEMADDR_PC  = 1'b0;
    localparam logic       CTL_MEMADDR_ALU = 1'b1;

    localparam logic [1:0] CTL_PC_PC4      = 2'd0;
    localparam logic [1:0] CTL_PC_PC_IMM   = 2'd1;
    localparam logic [1:0] CTL_PC_RS1_IMM  = 2'd2;

    localparam logic       CTL_ALU_A_RS1   = 1'b0;
    localparam logic       CTL_ALU_A_PC    = 1'b1;
    localparam logic       CTL_ALU_B_RS2   = 1'b0;
    localparam logic       CTL_ALU_B_IMM   = 1'b1;

    localparam logic [1:0] CTL_ALU_ADD     = 2'd0;
    localparam logic [1:0] CTL_ALU_OP      = 2'd1;
    localparam logic [1:0] CTL_ALU_OP_IMM  = 2'd2;
    localparam logic [1:0] CTL_ALU_BRANCH  = 2'd3;

    localparam logic [2:0] CTL_WRITEBACK_ALU  = 3'd0;
    localparam logic [2:0] CTL_WRITEBACK_DATA = 3'd1;
    localparam logic [2:0] CTL_WRITEBACK_IMM  = 3'd2;
    localparam logic [2:0] CTL_WRITEBACK_PC4  = 3'd3;

    // Opcodes the sequencer knows how to schedule; anything else is illegal.
    function automatic logic is_known_opcode(input logic [6:0] op);
        case (op)
            OPCODE_LOAD, OPCODE_MISC_MEM, OPCODE_OP_IMM, OPCODE_AUIPC,
            OPCODE_STORE, OPCODE_OP, OPCODE_LUI, OPCODE_BRANCH,
            OPCODE_JALR, OPCODE_JAL: is_known_opcode = 1'b1;
            default:                 is_known_opcode = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Unified memory port handshake between the sequencer and the memory.
interface multicycle_control_if;
    logic mem_addr_select;
    logic data_mem_read_enable;
    logic data_mem_write_enable;
    logic mem_ready;

    modport master (
        output mem_addr_select,
        output data_mem_read_enable,
        output data_mem_write_enable,
        input  mem_ready
    );

    modport slave (
        input  mem_addr_select,
        input  data_mem_read_enable,
        input  data_mem_write_enable,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_control_alu_select.sv
// Opcode to ALU operand/operation map, shared with the single-cycle decoder.
module multicycle_alu_select
    import multicycle_control_pkg::*;
(
    input  logic [6:0] inst_opcode,
    output logic       alu_operand_a_select,
    output logic       alu_operand_b_select,
    output logic [1:0] alu_op_type
);

    // Pure decode; opcodes without an ALU role leave the selects at zero.
    always_comb begin
        alu_operand_a_select = CTL_ALU_A_RS1;
        alu_operand_b_select = CTL_ALU_B_RS2;
        alu_op_type          = CTL_ALU_ADD;
        case (inst_opcode)
            OPCODE_LOAD, OPCODE_STORE, OPCODE_JALR: begin
                alu_operand_b_select = CTL_ALU_B_IMM;
            end
            OPCODE_AUIPC, OPCODE_JAL: begin
                alu_operand_a_select = CTL_ALU_A_PC;
                alu_operand_b_select = CTL_ALU_B_IMM;
            end
            OPCODE_OP: begin
                alu_op_type = CTL_ALU_OP;
            end
            OPCODE_OP_IMM: begin
                alu_operand_b_select = CTL_ALU_B_IMM;
                alu_op_type          = CTL_ALU_OP_IMM;
            end
            OPCODE_BRANCH: begin
                alu_op_type = CTL_ALU_BRANCH;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I sequencer. Optional trap on unknown opcodes is enabled
// with the ILLEGAL_INST_TRAP_EN macro (adds the illegal_inst port).
//
// state       | meaning
// S_FETCH     | read instruction at PC, wait for mem_ready, latch IR
// S_DECODE    | register file read; FENCE/NOP retire here
// S_EXECUTE   | ALU operation; branches retire here
// S_MEM       | load/store at ALU address, wait for mem_ready
// S_WRITEBACK | register write, PC update, retire
// S_TRAP      | illegal opcode seen; parked until reset (macro builds only)
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [6:0]             inst_opcode,
    input  logic                   take_branch,
    multicycle_control_if.master   mem_bus,
    output logic                   inst_write_enable,
    output logic                   mdr_write_enable,
    output logic                   pc_write_enable,
    output logic [1:0]             next_pc_select,
    output logic                   regfile_write_enable,
    output logic                   alu_operand_a_select,
    output logic                   alu_operand_b_select,
    output logic [1:0]             alu_op_type,
    output logic [2:0]             reg_writeback_select,
`ifdef ILLEGAL_INST_TRAP_EN
    output logic                   illegal_inst,
`endif
    output logic                   instr_retired
);

    state_t state, state_next;
    logic   map_a_sel, map_b_sel;
    logic [1:0] map_alu_op;

    multicycle_alu_select u_alu_select (
        .inst_opcode          (inst_opcode),
        .alu_operand_a_select (map_a_sel),
        .alu_operand_b_select (map_b_sel),
        .alu_op_type          (map_alu_op)
    );

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) state <= RESET_STATE;
        else          state <= state_next;
    end

    // Next-state and control outputs; ALU selects persist past EXECUTE since
    // the datapath has no ALU output register.
    always_comb begin
        state_next                    = state;
        mem_bus.mem_addr_select       = CTL_MEMADDR_PC;
        mem_bus.data_mem_read_enable  = 1'b0;
        mem_bus.data_mem_write_enable = 1'b0;
        inst_write_enable             = 1'b0;
        mdr_write_enable              = 1'b0;
        pc_write_enable               = 1'b0;
        next_pc_select                = CTL_PC_PC4;
        regfile_write_enable          = 1'b0;
        alu_operand_a_select          = CTL_ALU_A_RS1;
        alu_operand_b_select          = CTL_ALU_B_RS2;
        alu_op_type                   = CTL_ALU_ADD;
        reg_writeback_select          = CTL_WRITEBACK_ALU;
        instr_retired                 = 1'b0;
`ifdef ILLEGAL_INST_TRAP_EN
        illegal_inst                  = 1'b0;
`endif
        case (state)
            S_FETCH: begin
                mem_bus.data_mem_read_enable = 1'b1;
                if (mem_bus.mem_ready) begin
                    inst_write_enable = 1'b1;
                    state_next        = S_DECODE;
                end
            end
            S_DECODE: begin
                if (inst_opcode == OPCODE_MISC_MEM) begin
                    pc_write_enable = 1'b1;
                    instr_retired   = 1'b1;
                    state_next      = S_FETCH;
                end else if (is_known_opcode(inst_opcode)) begin
                    state_next = S_EXECUTE;
                end else begin
`ifdef ILLEGAL_INST_TRAP_EN
                    state_next = S_TRAP;
`else
                    pc_write_enable = 1'b1;
                    instr_retired   = 1'b1;
                    state_next      = S_FETCH;
`endif
                end
            end
            S_EXECUTE: begin
                alu_operand_a_select = map_a_sel;
                alu_operand_b_select = map_b_sel;
                alu_op_type          = map_alu_op;
                if (inst_opcode == OPCODE_BRANCH) begin
                    pc_write_enable = 1'b1;
                    next_pc_select  = take_branch ? CTL_PC_PC_IMM : CTL_PC_PC4;
                    instr_retired   = 1'b1;
                    state_next      = S_FETCH;
                end else if (inst_opcode == OPCODE_LOAD || inst_opcode == OPCODE_STORE) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WRITEBACK;
                end
            end
            S_MEM: begin
                alu_operand_a_select    = map_a_sel;
                alu_operand_b_select    = map_b_sel;
                alu_op_type             = map_alu_op;
                mem_bus.mem_addr_select = CTL_MEMADDR_ALU;
                if (inst_opcode == OPCODE_LOAD) begin
                    mem_bus.data_mem_read_enable = 1'b1;
                    if (mem_bus.mem_ready) begin
                        mdr_write_enable = 1'b1;
                        state_next       = S_WRITEBACK;
                    end
                end else begin
                    mem_bus.data_mem_write_enable = 1'b1;
                    if (mem_bus.mem_ready) begin
                        pc_write_enable = 1'b1;
                        instr_retired   = 1'b1;
                        state_next      = S_FETCH;
                    end
                end
            end
            S_WRITEBACK: begin
                alu_operand_a_select = map_a_sel;
                alu_operand_b_select = map_b_sel;
                alu_op_type          = map_alu_op;
                regfile_write_enable = 1'b1;
                pc_write_enable      = 1'b1;
                instr_retired        = 1'b1;
                state_next           = S_FETCH;
                case (inst_opcode)
                    OPCODE_LOAD: reg_writeback_select = CTL_WRITEBACK_DATA;
                    OPCODE_LUI:  reg_writeback_select = CTL_WRITEBACK_IMM;
                    OPCODE_JAL, OPCODE_JALR: reg_writeback_select = CTL_WRITEBACK_PC4;
                    default:     reg_writeback_select = CTL_WRITEBACK_ALU;
                endcase
                if (inst_opcode == OPCODE_JAL)       next_pc_select = CTL_PC_PC_IMM;
                else if (inst_opcode == OPCODE_JALR) next_pc_select = CTL_PC_RS1_IMM;
            end
`ifdef ILLEGAL_INST_TRAP_EN
            S_TRAP: begin
                illegal_inst = 1'b1;
            end
`endif
            default: state_next = RESET_STATE;
        endcase
        // A reset cycle never issues a request or commits anything.
        if (!reset_n) begin
            mem_bus.data_mem_read_enable  = 1'b0;
            mem_bus.data_mem_write_enable = 1'b0;
            inst_write_enable             = 1'b0;
            mdr_write_enable              = 1'b0;
            pc_write_enable               = 1'b0;
            regfile_write_enable          = 1'b0;
            instr_retired                 = 1'b0;
        end
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Sequencing FSM for the multicycle RV32I datapath. One instruction is spread over FETCH/DECODE/EXECUTE/MEM/WRITEBACK cycles.
- The block shares a single unified memory port between instruction fetch and data access, and handshakes with that memory through mem_ready.
- It drives the same control fields as the single-cycle decoder (`CTL_*` encodings), but as a state-sequenced schedule.
- PC changes only at the last cycle of an instruction, so PC stays stable for AUIPC/JAL/branch-target computation.

Parameters:
- RESET_STATE, S_FETCH, state entered on reset.

Ports:
- clock  in  1  system clock, rising-edge.
- reset_n  in  1  synchronous, active-low reset.
- inst_opcode  in  7  opcode from the instruction register; valid from DECODE onward.
- take_branch  in  1  branch comparator result; valid in EXECUTE.
- mem_ready  in  1  memory completion for the current read/write request.
- mem_addr_select  out  1  `CTL_MEMADDR_PC` (fetch) / `CTL_MEMADDR_ALU` (data).
- inst_write_enable  out  1  latch fetched word into the instruction register.
- mdr_write_enable  out  1  latch load data into the memory data register.
- pc_write_enable  out  1  update PC with the next_pc_select source.
- next_pc_select  out  2  `CTL_PC_PC4` / `CTL_PC_PC_IMM` / `CTL_PC_RS1_IMM`.
- regfile_write_enable  out  1  register file write.
- alu_operand_a_select  out  1  `CTL_ALU_A_RS1` / `CTL_ALU_A_PC`.
- alu_operand_b_select  out  1  `CTL_ALU_B_RS2` / `CTL_ALU_B_IMM`.
- alu_op_type  out  2  `CTL_ALU_ADD` / `_OP` / `_OP_IMM` / `_BRANCH`.
- data_mem_read_enable  out  1  memory read request (fetch or load).
- data_mem_write_enable  out  1  memory write request (store).
- reg_writeback_select  out  3  `CTL_WRITEBACK_ALU` / `_DATA` / `_IMM` / `_PC4`.
- instr_retired  out  1  one-cycle pulse on the cycle the PC is written.

Behaviour:
- Reset and output defaults:
  - While reset_n is low, all enables and instr_retired are forced to 0 combinationally.
  - On a clock edge with reset_n low, state becomes S_FETCH.
  - Reset mid-request abandons the access; no write is ever issued from a reset cycle.
  - Default values outside the states that set them: selects 0, enables 0.
- S_FETCH:
  - Drives mem_addr_select=PC and data_mem_read_enable=1.
  - Stays in S_FETCH while mem_ready=0. The request is held stable; no other enable is asserted.
  - When mem_ready=1: inst_write_enable=1 for that cycle, next state S_DECODE.
- S_DECODE:
  - No enables asserted; the register file is read.
  - MISC_MEM (FENCE): pc_write_enable=1, next_pc_select=PC4, instr_retired=1, next state S_FETCH.
  - Valid opcode: next state S_EXECUTE.
  - Unknown opcode: see Optional Feature.
- S_EXECUTE: ALU selects per opcode are identical to the single-cycle mapping.
  - LOAD/STORE/JALR: A=RS1, B=IMM, ADD.
  - AUIPC/JAL: A=PC, B=IMM, ADD.
  - OP: A=RS1, B=RS2, OP.
  - OP_IMM: A=RS1, B=IMM, OP_IMM.
  - BRANCH:
    - A=RS1, B=RS2, BRANCH; pc_write_enable=1, instr_retired=1, next state S_FETCH.
    - next_pc_select=PC_IMM if take_branch else PC4.
  - LOAD/STORE: next state S_MEM.
  - All others: next state S_WRITEBACK.
  - ALU selects are held unchanged through S_MEM and S_WRITEBACK, because the datapath has no ALUOut register.
- S_MEM: mem_addr_select=ALU.
  - LOAD asserts data_mem_read_enable; STORE asserts data_mem_write_enable.
  - While mem_ready=0: stay in S_MEM.
  - LOAD, mem_ready=1: mdr_write_enable=1, next state S_WRITEBACK.
  - STORE, mem_ready=1: pc_write_enable=1 (PC4), instr_retired=1, next state S_FETCH.
- S_WRITEBACK: regfile_write_enable=1, pc_write_enable=1, instr_retired=1, next state S_FETCH.
  - reg_writeback_select: LOAD→DATA, LUI→IMM, JAL/JALR→PC4, others→ALU.
  - next_pc_select: JAL→PC_IMM, JALR→RS1_IMM, others→PC4.
- Latency with mem_ready tied high:
  - FENCE: 2 cycles. Branch: 3 cycles.
  - ALU/LUI/AUIPC/JAL/JALR: 4 cycles. Store: 4 cycles. Load: 5 cycles.
  - Each memory wait cycle adds 1.
- Invariants:
  - data_mem_read_enable and data_mem_write_enable are never both 1.
  - pc_write_enable implies instr_retired.
  - At most one memory request is outstanding.

Optional Feature:
- Macro: `ILLEGAL_INST_TRAP_EN`.
- Defined:
  - Unknown opcode in S_DECODE moves to S_TRAP.
  - S_TRAP asserts extra output illegal_inst=1, holds all enables 0, and stays there until reset.
  - The illegal_inst port exists only when the macro is defined.
- Undefined:
  - Unknown opcode is treated as a NOP: pc_write_enable=1 (PC4), instr_retired=1 in S_DECODE, next state S_FETCH.
  - S_TRAP does not exist.

Decomposition:
- constants.sv gains:
  - `CTL_MEMADDR_PC`=1'b0 and `CTL_MEMADDR_ALU`=1'b1.
  - The state typedef: enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_TRAP}.
- Existing `OPCODE_*` and `CTL_*` macros are reused unchanged.
- Sub-module: multicycle_alu_select, a pure-combinational opcode→{a_sel, b_sel, alu_op} map, instantiated once and used in EXECUTE/MEM/WRITEBACK.

Test Plan:
- reset_n=0 for 2 cycles mid-S_MEM of a store → data_mem_write_enable=0 during reset; next cycle state=S_FETCH, data_mem_read_enable=1.
- ADDI (opcode 0010011), mem_ready=1 → instr_retired on cycle 4.
  - Cycle 4 shows regfile_write_enable=1, select=ALU, b_sel=IMM, alu_op=OP_IMM.
- LW with mem_ready low 3 cycles in S_FETCH and 2 in S_MEM → retire on cycle 10.
  - mdr_write_enable pulses exactly once, on the S_MEM ready cycle.
- BEQ (1100011):
  - take_branch=1 → cycle 3 pc_write_enable=1, next_pc_select=PC_IMM.
  - take_branch=0 → next_pc_select=PC4.
  - regfile_write_enable stays 0 in both cases.
- JALR then SW back-to-back:
  - JALR writeback cycle: select=PC4, next_pc=RS1_IMM.
  - SW S_MEM cycle: mem_addr_select=ALU, write_enable=1.
- Opcode 7'h7F:
  - With the macro: illegal_inst=1 permanently, no further fetch.
  - Without the macro: retire in 2 cycles with next_pc=PC4.
